// File: rtl/conv_pad_inserter.sv
// Streaming zero-pad stage: surrounds an NHWC frame with a 1-pixel zero border ahead of kernelWindow.
// Optional macro PAD_BYPASS_EN adds a pad_bypass port that turns the stage into a registered pass-through.
module conv_pad_inserter #(
   parameter int DATA_W = 64,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  in_channels,
   input  logic [DIM_W-1:0]  img_width,
   input  logic [DIM_W-1:0]  img_height,
`ifdef PAD_BYPASS_EN
   input  logic              pad_bypass,
`endif
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] pixel_out,
   output logic              pixel_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);
   localparam int CNT_W = DIM_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  ci_q, ci_d, cg_q, cg_d;
   logic [CNT_W-1:0]  wp_q, wp_d, hp_q, hp_d, col_q, col_d, row_q, row_d;
   logic [DATA_W-1:0] pix_q, pix_d;
   logic              pvalid_q, pvalid_d, last_q, last_d, all_q, all_d;
   logic              cfg_err_q, cfg_err_d, byp_q, byp_d;

   logic              start_byp, cfg_bad, border, last_pos, can_load, load;
   logic [CNT_W-1:0]  pad_amt;
   logic [DIM_W-1:0]  ci_new;

`ifdef PAD_BYPASS_EN
   assign start_byp = pad_bypass;
`else
   assign start_byp = 1'b0;
`endif

   assign cfg_bad  = (in_channels[2:0] != 3'd0) || (in_channels == '0) ||
                     (img_width == '0) || (img_height == '0);
   assign ci_new   = in_channels >> 3;
   assign pad_amt  = start_byp ? CNT_W'(0) : CNT_W'(2);

   assign border   = !byp_q && ((row_q == '0) || (row_q == hp_q - CNT_W'(1)) ||
                                (col_q == '0) || (col_q == wp_q - CNT_W'(1)));
   assign last_pos = (row_q == hp_q - CNT_W'(1)) && (col_q == wp_q - CNT_W'(1)) &&
                     (cg_q == ci_q - DIM_W'(1));
   assign can_load = !pvalid_q || m_ready;
   // all_q blocks further loads once the final vector is in the output register.
   assign load     = (state_q == S_STREAM) && !all_q && can_load && (border || s_valid);
   assign s_ready  = (state_q == S_STREAM) && !all_q && !border && can_load;

   assign pixel_out   = pix_q;
   assign pixel_valid = pvalid_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign cfg_err     = cfg_err_q;

   always_comb begin
      // NOTE: every _d gets a default before the case so no path can infer a latch.
      state_d   = state_q;
      ci_d      = ci_q;
      wp_d      = wp_q;
      hp_d      = hp_q;
      cg_d      = cg_q;
      col_d     = col_q;
      row_d     = row_q;
      pix_d     = pix_q;
      pvalid_d  = pvalid_q;
      last_d    = last_q;
      all_d     = all_q;
      byp_d     = byp_q;
      cfg_err_d = 1'b0;

      if (pvalid_q && m_ready) pvalid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  state_d = S_STREAM;
                  ci_d    = ci_new;
                  wp_d    = {1'b0, img_width} + pad_amt;
                  hp_d    = {1'b0, img_height} + pad_amt;
                  byp_d   = start_byp;
                  row_d   = '0;
                  col_d   = '0;
                  cg_d    = '0;
                  all_d   = 1'b0;
                  last_d  = 1'b0;
                  // The top-left corner is always border, so it is emitted on the start edge.
                  if (!start_byp) begin
                     pvalid_d = 1'b1;
                     pix_d    = '0;
                     if (ci_new == DIM_W'(1)) col_d = CNT_W'(1);
                     else                     cg_d  = DIM_W'(1);
                  end
               end
            end
         end
         S_STREAM: begin
            if (load) begin
               pix_d    = border ? '0 : s_data;
               pvalid_d = 1'b1;
               last_d   = last_pos;
               if (last_pos) all_d = 1'b1;
               if (cg_q == ci_q - DIM_W'(1)) begin
                  cg_d = '0;
                  if (col_q == wp_q - CNT_W'(1)) begin
                     col_d = '0;
                     row_d = (row_q == hp_q - CNT_W'(1)) ? '0 : row_q + CNT_W'(1);
                  end else begin
                     col_d = col_q + CNT_W'(1);
                  end
               end else begin
                  cg_d = cg_q + DIM_W'(1);
               end
            end
            if (pvalid_q && m_ready && last_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ci_q      <= '0;
         wp_q      <= '0;
         hp_q      <= '0;
         cg_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         pix_q     <= '0;
         pvalid_q  <= 1'b0;
         last_q    <= 1'b0;
         all_q     <= 1'b0;
         byp_q     <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ci_q      <= ci_d;
         wp_q      <= wp_d;
         hp_q      <= hp_d;
         cg_q      <= cg_d;
         col_q     <= col_d;
         row_q     <= row_d;
         pix_q     <= pix_d;
         pvalid_q  <= pvalid_d;
         last_q    <= last_d;
         all_q     <= all_d;
         byp_q     <= byp_d;
         cfg_err_q <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_conv_pad_inserter.sv
// Directed bench for conv_pad_inserter: padded frames, stalls, restart, bad config, mid-frame reset.
// Each accepted beat is compared with an index-arithmetic model of the padded NHWC order.
module tb_conv_pad_inserter;
   localparam int DATA_W = 64;
   localparam int DIM_W  = 16;

   logic              clk = 1'b0;
   logic              rst, start, s_valid, s_ready, pixel_valid, m_ready, busy, done, cfg_err;
   logic [DIM_W-1:0]  in_channels, img_width, img_height;
   logic [DATA_W-1:0] s_data, pixel_out;
`ifdef PAD_BYPASS_EN
   logic              pad_bypass;
`endif

   int                vectors     = 0;
   int                miscompares = 0;
   logic [DATA_W-1:0] beat7;

   always #5 clk = ~clk;

   conv_pad_inserter #(.DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_channels (in_channels),
      .img_width   (img_width),
      .img_height  (img_height),
`ifdef PAD_BYPASS_EN
      .pad_bypass  (pad_bypass),
`endif
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .pixel_out   (pixel_out),
      .pixel_valid (pixel_valid),
      .m_ready     (m_ready),
      .busy        (busy),
      .done        (done),
      .cfg_err     (cfg_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] in_word(input int i);
      return {16'hC0DE, 16'(i), 32'(i * 40503 + 7)};
   endfunction

   // Expected k-th padded output vector, derived from position arithmetic alone.
   function automatic logic [63:0] exp_beat(input int k, input int w, input int h, input int ci,
                                            input bit byp);
      int wp, hp, cg, pos, col, row;
      if (byp) return in_word(k);
      wp  = w + 2;
      hp  = h + 2;
      cg  = k % ci;
      pos = k / ci;
      col = pos % wp;
      row = pos / wp;
      if (row == 0 || row == hp - 1 || col == 0 || col == wp - 1) return '0;
      return in_word(((row - 1) * w + (col - 1)) * ci + cg);
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_valid"},  64'(pixel_valid), 64'd0);
      check({tag, "_data"},   pixel_out,        64'd0);
      check({tag, "_busy"},   64'(busy),        64'd0);
      check({tag, "_done"},   64'(done),        64'd0);
      check({tag, "_sready"}, 64'(s_ready),     64'd0);
      check({tag, "_cfgerr"}, 64'(cfg_err),     64'd0);
   endtask

   task automatic run_frame(input int w, input int h, input int ci, input bit byp, input bit stall,
                            input int restart_at, input int abort_at);
      int                n_out, n_in, n_done, total_in, total_out, cyc;
      bit                held, restarted, fin;
      logic [63:0]       held_data;
      total_in  = w * h * ci;
      total_out = byp ? total_in : (w + 2) * (h + 2) * ci;
      n_out = 0; n_in = 0; n_done = 0; cyc = 0;
      held = 1'b0; restarted = 1'b0; fin = 1'b0; held_data = '0;

      @(posedge clk); #1;
      img_width   = DIM_W'(w);
      img_height  = DIM_W'(h);
      in_channels = DIM_W'(ci * 8);
`ifdef PAD_BYPASS_EN
      pad_bypass  = byp;
`endif
      start   = 1'b1;
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = in_word(0);
      #1;
      check("idle_sready", 64'(s_ready), 64'd0);
      check("idle_busy",   64'(busy),    64'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("first_busy",  64'(busy),        64'd1);
      check("first_valid", 64'(pixel_valid), 64'(!byp));

      while (!fin && cyc < 3000) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
         end
         start = 1'b0;
         if (restart_at >= 0 && n_out == restart_at && !restarted) begin
            start     = 1'b1;
            restarted = 1'b1;
            img_width = DIM_W'(w + 3);
         end
         m_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         s_valid = (n_in < total_in) && (!stall || $urandom_range(0, 3) != 0);
         s_data  = in_word(n_in);
         #1;
         if (held) begin
            check("stall_valid", 64'(pixel_valid), 64'd1);
            check("stall_data",  pixel_out,        held_data);
         end
         if (abort_at >= 0 && n_out == abort_at) begin
            rst = 1'b1;
            #1;
            check_quiet("abort");
            @(negedge clk);
            rst     = 1'b0;
            s_valid = 1'b0;
            start   = 1'b0;
            return;
         end
         if (pixel_valid && m_ready) begin
            check($sformatf("beat%0d", n_out), pixel_out, exp_beat(n_out, w, h, ci, byp));
            if (n_out == 7) beat7 = pixel_out;
            n_out++;
         end
         held      = pixel_valid && !m_ready;
         held_data = pixel_out;
         if (s_valid && s_ready) n_in++;
         if (done) begin
            n_done++;
            fin = 1'b1;
         end
         cyc++;
      end
      start   = 1'b0;
      s_valid = 1'b0;

      check("frame_done", 64'(fin), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         check("post_valid", 64'(pixel_valid), 64'd0);
      end
      check("beats",       64'(n_out),  64'(total_out));
      check("consumed",    64'(n_in),   64'(total_in));
      check("done_pulses", 64'(n_done), 64'd1);
      check("post_busy",   64'(busy),   64'd0);
   endtask

   task automatic bad_cfg(input string tag, input int ch, input int w, input int h);
      @(posedge clk); #1;
      in_channels = DIM_W'(ch);
      img_width   = DIM_W'(w);
      img_height  = DIM_W'(h);
`ifdef PAD_BYPASS_EN
      pad_bypass  = 1'b0;
`endif
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_cfgerr"}, 64'(cfg_err), 64'd1);
      check({tag, "_busy"},   64'(busy),    64'd0);
      @(posedge clk); #1;
      check({tag, "_cfgerr_drop"}, 64'(cfg_err), 64'd0);
      check({tag, "_busy_after"},  64'(busy),    64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      in_channels = '0; img_width = '0; img_height = '0; beat7 = 'x;
`ifdef PAD_BYPASS_EN
      pad_bypass = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      @(negedge clk);
      rst = 1'b0;

      // 4x4x8: 36 beats, 16 consumed, vector 7 is the first input
      run_frame(4, 4, 1, 1'b0, 1'b0, -1, -1);
      check("vec7", beat7, 64'hC0DE_0000_0000_0007);

      // 4x4x16: 72 beats, channel groups interleaved per pixel
      run_frame(4, 4, 2, 1'b0, 1'b0, -1, -1);

      // 5x3x8 with random downstream stalls and input gaps: same 35-beat sequence
      run_frame(5, 3, 1, 1'b0, 1'b1, -1, -1);

      // start at beat 10 while busy is ignored
      run_frame(4, 4, 1, 1'b0, 1'b0, 10, -1);

      bad_cfg("ch12", 12, 4, 4);
      bad_cfg("w0",   8,  0, 4);

      // reset at beat 20, then a clean frame
      run_frame(4, 4, 1, 1'b0, 1'b0, -1, 20);
      run_frame(4, 4, 1, 1'b0, 1'b0, -1, -1);

`ifdef PAD_BYPASS_EN
      run_frame(4, 4, 1, 1'b1, 1'b0, -1, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
